muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/booth_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   seqState_t  : sequencer state encoding
//   OP_MULT     : op value for a signed multiply
//   OP_DIV      : op value for a signed divide
//   ITER_COUNT  : number of iteration cycles per MULT/DIV
//   CNT_W       : width of the iteration counter
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } seqState_t;

    localparam logic OP_MULT    = 1'b0;
    localparam logic OP_DIV     = 1'b1;
    localparam int   ITER_COUNT = 32;
    localparam int   CNT_W      = $clog2(ITER_COUNT);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   accIn/accOut   : running partial product, one guard bit above WIDTH
//   mplrIn/mplrOut : multiplier, collecting low product bits as it shifts
//   qm1In/qm1Out   : Booth history bit (bit shifted out last step)
//   mcand          : signed multiplicand
// The guard bit keeps +/-multiplicand in range when the multiplicand is
// the most negative value.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   accIn,
    input  logic [WIDTH-1:0] mplrIn,
    input  logic             qm1In,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH:0]   accOut,
    output logic [WIDTH-1:0] mplrOut,
    output logic             qm1Out
);

    logic [WIDTH:0] mcandExt;
    logic [WIDTH:0] sum;

    always_comb begin
        mcandExt = {mcand[WIDTH-1], mcand};
        unique case ({mplrIn[0], qm1In})
            2'b01:   sum = accIn + mcandExt;
            2'b10:   sum = accIn - mcandExt;
            default: sum = accIn;
        endcase
        // arithmetic shift right of the {acc, mplr, qm1} chain
        accOut  = {sum[WIDTH], sum[WIDTH:1]};
        mplrOut = {sum[0], mplrIn[WIDTH-1:1]};
        qm1Out  = mplrIn[0];
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed 32x32 multiply / 32/32 divide sequencer.
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset
//   start    : begin an operation (only honoured in IDLE)
//   op       : 0 = signed multiply, 1 = signed divide
//   src_a    : multiplicand / dividend
//   src_b    : multiplier / divisor
//   hi, lo   : MULT -> product[63:32], product[31:0]; DIV -> remainder, quotient
//   busy     : operation in progress (state != IDLE)
//   done     : one-cycle result-valid pulse
//   div_zero : one-cycle pulse with done for a divide by zero
//
// state | meaning
// IDLE  | waiting for start
// MULT  | one Booth step per cycle, 32 cycles
// DIV   | one restoring-division step per cycle on magnitudes, 32 cycles
// DONE  | result on hi/lo, done high for this cycle
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    seqState_t        state;
    logic [CNT_W-1:0] iterCnt;
    // acc/mplr/mcand are shared: MULT uses them as Booth registers,
    // DIV as remainder / dividend-then-quotient / divisor magnitude.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] mcand;
    logic             qm1;
    logic             negQuot;
    logic             negRem;

    logic [WIDTH:0]   boothAcc;
    logic [WIDTH-1:0] boothMplr;
    logic             boothQm1;

    logic [WIDTH:0]   divShifted;
    logic [WIDTH:0]   divDiff;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quotNext;

    booth_step #(.WIDTH(WIDTH)) uBoothStep (
        .accIn   (acc),
        .mplrIn  (mplr),
        .qm1In   (qm1),
        .mcand   (mcand),
        .accOut  (boothAcc),
        .mplrOut (boothMplr),
        .qm1Out  (boothQm1)
    );

    // Restoring division step: shift the next dividend bit into the
    // remainder and keep the difference when it did not borrow.
    always_comb begin
        divShifted = {acc[WIDTH-1:0], mplr[WIDTH-1]};
        divDiff    = divShifted - {1'b0, mcand};
        remNext    = divDiff[WIDTH] ? divShifted[WIDTH-1:0] : divDiff[WIDTH-1:0];
        quotNext   = {mplr[WIDTH-2:0], ~divDiff[WIDTH]};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            iterCnt  <= '0;
            acc      <= '0;
            mplr     <= '0;
            mcand    <= '0;
            qm1      <= 1'b0;
            negQuot  <= 1'b0;
            negRem   <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        iterCnt <= '0;
                        acc     <= '0;
                        qm1     <= 1'b0;
                        if (op == OP_MULT) begin
                            mplr  <= src_b;
                            mcand <= src_a;
                            state <= MULT;
                        end else begin
                            mplr    <= src_a[WIDTH-1] ? (~src_a + WIDTH'(1)) : src_a;
                            mcand   <= src_b[WIDTH-1] ? (~src_b + WIDTH'(1)) : src_b;
                            negQuot <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                            negRem  <= src_a[WIDTH-1];
                            state   <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc     <= boothAcc;
                    mplr    <= boothMplr;
                    qm1     <= boothQm1;
                    iterCnt <= iterCnt + CNT_W'(1);
                    if (iterCnt == LAST_ITER) begin
                        // product fits in 64 bits, so the guard bit is redundant here
                        hi    <= boothAcc[WIDTH-1:0];
                        lo    <= boothMplr;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DIV: begin
                    if (mcand == '0) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                        state    <= DONE;
                    end else begin
                        acc     <= {1'b0, remNext};
                        mplr    <= quotNext;
                        iterCnt <= iterCnt + CNT_W'(1);
                        if (iterCnt == LAST_ITER) begin
                            // quotient truncates toward zero, remainder follows dividend sign
                            hi    <= negRem  ? (~remNext  + WIDTH'(1)) : remNext;
                            lo    <= negQuot ? (~quotNext + WIDTH'(1)) : quotNext;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int errors = 0;
    int checks = 0;
    bit chkEn  = 1'b0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit signed arithmetic.
    function automatic logic [63:0] refResult(input logic o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 1'b0) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural timing model: an accepted op finishes 32 edges later
    // (1 for divide by zero), busy drops one edge after that.
    logic        mActive = 1'b0;
    int          mAge = 0;
    int          finishAge = 0;
    logic        pendDz = 1'b0;
    logic [63:0] pendRes = '0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic        mDone = 1'b0;
    logic        mDz = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            mActive = 1'b0;
            mHi = '0;
            mLo = '0;
            mDone = 1'b0;
            mDz = 1'b0;
        end else begin
            mDone = 1'b0;
            mDz = 1'b0;
            if (mActive) begin
                mAge++;
                if (mAge == finishAge) begin
                    if (!pendDz) begin
                        mHi = pendRes[63:32];
                        mLo = pendRes[31:0];
                    end
                    mDone = 1'b1;
                    mDz = pendDz;
                end else if (mAge == finishAge + 1) begin
                    mActive = 1'b0;
                end
            end else if (start) begin
                mActive = 1'b1;
                mAge = 0;
                pendDz = op && (src_b == 32'd0);
                finishAge = pendDz ? 1 : 32;
                if (!pendDz) pendRes = refResult(op, src_a, src_b);
            end
        end
    end

    always @(negedge clock) begin
        if (chkEn) begin
            check("flags", {61'd0, busy, done, div_zero}, {61'd0, mActive, mDone, mDz});
            check("hi", {32'd0, hi}, {32'd0, mHi});
            check("lo", {32'd0, lo}, {32'd0, mLo});
        end
    end

    task automatic doStart(input logic o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(output logic [31:0] h, output logic [31:0] l, output logic dz, output int lat);
        h = '0;
        l = '0;
        dz = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            lat++;
            if (done) begin
                h = hi;
                l = lo;
                dz = div_zero;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done required done within 40 cycles at %0t", $time);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] rh, rl;
    logic        rdz;
    int          lat;
    int          doneCnt;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        src_a = '0;
        src_b = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {62'd0, done, div_zero}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        chkEn = 1'b1;

        // pin the reference model to hand-computed values
        check("model_mul_7x-3", refResult(1'b0, 32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        check("model_div_7/-2", refResult(1'b1, 32'd7, 32'hFFFF_FFFE), 64'h0000_0001_FFFF_FFFD);
        check("model_div_-7/2", refResult(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_mul_min", refResult(1'b0, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        check("model_div_min", refResult(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        doStart(1'b0, 32'd7, 32'hFFFF_FFFD);
        waitDone(rh, rl, rdz, lat);
        check("mul_7x-3", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul_latency", 64'(lat), 64'd32);

        doStart(1'b1, 32'd7, 32'hFFFF_FFFE);
        waitDone(rh, rl, rdz, lat);
        check("div_7/-2", {rh, rl}, 64'h0000_0001_FFFF_FFFD);
        check("div_latency", 64'(lat), 64'd32);

        doStart(1'b1, 32'hFFFF_FFF9, 32'd2);
        waitDone(rh, rl, rdz, lat);
        check("div_-7/2", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);

        doStart(1'b0, 32'h8000_0000, 32'h8000_0000);
        waitDone(rh, rl, rdz, lat);
        check("mul_min_x_min", {rh, rl}, 64'h4000_0000_0000_0000);

        doStart(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(rh, rl, rdz, lat);
        check("div_min/-1", {rh, rl}, 64'h0000_0000_8000_0000);
        check("div_min/-1_flag", {63'd0, rdz}, 64'd0);

        doStart(1'b1, 32'd5, 32'd0);
        waitDone(rh, rl, rdz, lat);
        check("divzero_latency", 64'(lat), 64'd1);
        check("divzero_flag", {63'd0, rdz}, 64'd1);
        check("divzero_hold", {rh, rl}, 64'h0000_0000_8000_0000);

        // start with new operands mid-DIV must be ignored
        doStart(1'b1, 32'd100, 32'd7);
        repeat (5) @(negedge clock);
        start = 1'b1;
        op    = 1'b0;
        src_a = 32'd1000;
        src_b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        waitDone(rh, rl, rdz, lat);
        check("div_ignore_start", {rh, rl}, 64'h0000_0002_0000_000E);
        // back-to-back start in the IDLE cycle right after DONE
        doStart(1'b0, 32'd12345, 32'hFFFF_FD5A);
        waitDone(rh, rl, rdz, lat);
        check("b2b_mul", {rh, rl}, 64'hFFFF_FFFF_FF80_490A);
        check("b2b_latency", 64'(lat), 64'd32);

        // reset 10 cycles into a MULT
        doStart(1'b0, 32'd123, 32'd456);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        doneCnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) doneCnt++;
        end
        check("abort_no_done", 64'(doneCnt), 64'd0);

        // randomized traffic, including starts while busy
        repeat (8000) begin
            @(negedge clock);
            start = ($urandom_range(0, 3) == 0);
            op    = 1'($urandom_range(0, 1));
            src_a = randOperand();
            src_b = randOperand();
        end
        start = 1'b0;
        repeat (40) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
